// File: rtl/color_select_if.sv
// Pushbutton and colour-code signals of the colour selector.
// The bench drives the keys through the master side; color_select is the slave.
interface color_select_if;
  logic       key_next_n;
  logic       key_prev_n;
  logic [2:0] color;
  logic       color_changed;

  modport master (
    output key_next_n,
    output key_prev_n,
    input  color,
    input  color_changed
  );

  modport slave (
    input  key_next_n,
    input  key_prev_n,
    output color,
    output color_changed
  );
endinterface

// File: rtl/color_select.sv
// Two-button colour selector: synchronized and debounced keys step a 3-bit
// colour code up or down, with hold-to-repeat and a lockout when both are held.
module color_select #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic           clk,
  input  logic           reset,
  color_select_if.slave  io_bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYCLES);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_HELD_NEXT = 2'd1,
    S_HELD_PREV = 2'd2,
    S_LOCKED    = 2'd3
  } state_t;

  // Index 0 is the next key, index 1 the prev key.
  logic [1:0]        r_sync1;
  logic [1:0]        r_sync2;
  logic [1:0]        r_db;
  logic [1:0]        r_db_d;
  logic [DB_W-1:0]   r_db_cnt [2];
  logic [1:0]        w_lvl;
  logic [1:0]        w_rise;

  state_t            r_state;
  state_t            w_state_next;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [REP_W-1:0]  r_rep_cnt;
  logic              w_timer_due;
  logic              w_step_inc;
  logic              w_step_dec;

  logic [2:0]        r_color;
  logic              r_color_changed;

  assign w_lvl  = ~r_sync2;
  assign w_rise = r_db & ~r_db_d;

  // Synchronizers and per-key debouncers; the counter restarts whenever the
  // synchronized level agrees with the accepted state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_db    <= 2'b00;
      r_db_d  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= {io_bus.key_prev_n, io_bus.key_next_n};
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (w_lvl[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= ~r_db[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; the other key appearing while one is held locks out
  // stepping until both keys are released.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_db[0] && r_db[1]) begin
          w_state_next = S_LOCKED;
        end else if (w_rise[0]) begin
          w_state_next = S_HELD_NEXT;
        end else if (w_rise[1]) begin
          w_state_next = S_HELD_PREV;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_HELD_NEXT: begin
        if (r_db[1]) begin
          w_state_next = S_LOCKED;
        end else if (!r_db[0]) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_HELD_NEXT;
        end
      end
      S_HELD_PREV: begin
        if (r_db[0]) begin
          w_state_next = S_LOCKED;
        end else if (!r_db[1]) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_HELD_PREV;
        end
      end
      S_LOCKED: begin
        if (r_db == 2'b00) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_LOCKED;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_timer_due = (r_hold_cnt == HOLD_LAST) ||
                       ((r_hold_cnt == HOLD_SAT) && (r_rep_cnt == REP_LAST));

  // Step requests: one on the initial press, then timed repeats while held.
  always_comb begin
    w_step_inc = 1'b0;
    w_step_dec = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_step_inc = (w_state_next == S_HELD_NEXT);
        w_step_dec = (w_state_next == S_HELD_PREV);
      end
      S_HELD_NEXT: begin
        w_step_inc = (w_state_next == S_HELD_NEXT) && w_timer_due;
      end
      S_HELD_PREV: begin
        w_step_dec = (w_state_next == S_HELD_PREV) && w_timer_due;
      end
      default: begin
        w_step_inc = 1'b0;
        w_step_dec = 1'b0;
      end
    endcase
  end

  // Hold counter saturates at HOLD_CYCLES; the repeat counter only runs after.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
    end else if ((w_state_next != r_state) ||
                 ((r_state != S_HELD_NEXT) && (r_state != S_HELD_PREV))) begin
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
    end else if (r_hold_cnt != HOLD_SAT) begin
      r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      r_rep_cnt  <= '0;
    end else if (r_rep_cnt == REP_LAST) begin
      r_rep_cnt  <= '0;
    end else begin
      r_rep_cnt  <= r_rep_cnt + REP_W'(1);
    end
  end

  // Colour register, wrapping modulo 8, with its change pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_color         <= 3'b001;
      r_color_changed <= 1'b0;
    end else if (w_step_inc) begin
      r_color         <= r_color + 3'd1;
      r_color_changed <= 1'b1;
    end else if (w_step_dec) begin
      r_color         <= r_color - 3'd1;
      r_color_changed <= 1'b1;
    end else begin
      r_color_changed <= 1'b0;
    end
  end

  assign io_bus.color         = r_color;
  assign io_bus.color_changed = r_color_changed;

endmodule

// File: tb/tb_color_select.sv
// Scoreboard bench for color_select with short debounce/hold/repeat periods:
// stimulus queues expected (edge, colour) steps, a monitor checks every pulse.
module tb_color_select;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  int   exp_cyc_q[$];
  int   exp_col_q[$];

  always #5 clk = ~clk;

  color_select_if bus ();

  color_select #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Every color_changed pulse must match the next expected step.
  always @(negedge clk) begin
    if (bus.color_changed === 1'b1) begin
      if (exp_cyc_q.size() == 0) begin
        check("unexpected_step_edge", cyc, -1);
      end else begin
        int e_cyc;
        int e_col;
        e_cyc = exp_cyc_q.pop_front();
        e_col = exp_col_q.pop_front();
        check("step_edge", cyc, e_cyc);
        check("step_color", int'(bus.color), e_col);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_step(input int at_edge, input int col);
    exp_cyc_q.push_back(at_edge);
    exp_col_q.push_back(col);
  endtask

  task automatic do_reset(output int base);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base = cyc;
    check("reset_color", int'(bus.color), 1);
    check("reset_changed", int'(bus.color_changed), 0);
  endtask

  task automatic check_drained(input int col);
    check("queue_drained", exp_cyc_q.size(), 0);
    check("final_color", int'(bus.color), col);
  endtask

  initial begin
    int base;
    int hold_edges[9];
    int hold_cols[9];
    hold_edges = '{7, 17, 20, 23, 26, 29, 32, 35, 38};
    hold_cols  = '{2, 3, 4, 5, 6, 7, 0, 1, 2};
    bus.key_next_n = 1'b1;
    bus.key_prev_n = 1'b1;
    wait_cyc(3);

    // Continuous next hold: first step, hold delay, repeats, wrap 111->000.
    // Release after edge 32: debounced release lands at edge 38, so the
    // repeats at 35 and 38 still happen.
    do_reset(base);
    for (int i = 0; i < 9; i++) expect_step(base + hold_edges[i], hold_cols[i]);
    bus.key_next_n = 1'b0;
    wait_cyc(32);
    bus.key_next_n = 1'b1;
    wait_cyc(14);
    check_drained(2);

    // Prev glitch shorter than the debounce window: no step.
    do_reset(base);
    bus.key_prev_n = 1'b0;
    wait_cyc(3);
    bus.key_prev_n = 1'b1;
    wait_cyc(1);
    bus.key_prev_n = 1'b0;
    wait_cyc(3);
    bus.key_prev_n = 1'b1;
    wait_cyc(12);
    check_drained(1);

    // Two single prev presses: 001 -> 000 -> 111.
    base = cyc;
    expect_step(base + 7, 0);
    bus.key_prev_n = 1'b0;
    wait_cyc(9);
    bus.key_prev_n = 1'b1;
    wait_cyc(12);
    check_drained(0);
    base = cyc;
    expect_step(base + 7, 7);
    bus.key_prev_n = 1'b0;
    wait_cyc(9);
    bus.key_prev_n = 1'b1;
    wait_cyc(12);
    check_drained(7);

    // Both keys together lock out; stepping resumes only after a fresh press.
    do_reset(base);
    bus.key_next_n = 1'b0;
    bus.key_prev_n = 1'b0;
    wait_cyc(30);
    bus.key_next_n = 1'b1;
    wait_cyc(12);
    check_drained(1);
    bus.key_prev_n = 1'b1;
    wait_cyc(12);
    check_drained(1);
    base = cyc;
    expect_step(base + 7, 2);
    bus.key_next_n = 1'b0;
    wait_cyc(9);
    bus.key_next_n = 1'b1;
    wait_cyc(12);
    check_drained(2);

    // Reset at edge 15 of a next hold; held key re-debounces and steps once.
    do_reset(base);
    expect_step(base + 7, 2);
    bus.key_next_n = 1'b0;
    wait_cyc(14);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    check("midhold_reset_color", int'(bus.color), 1);
    check("midhold_reset_changed", int'(bus.color_changed), 0);
    check("midhold_reset_edge", cyc - base, 15);
    base = cyc;
    expect_step(base + 7, 2);
    wait_cyc(9);
    bus.key_next_n = 1'b1;
    wait_cyc(12);
    check_drained(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
